// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: read ports, write port, reservation port and Ready.
interface param_register_file_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic              BusyA;
    logic              BusyB;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] BusW;
    logic              RegWr;
    logic              RsvVld;
    logic [ADDR_W-1:0] RsvIdx;
    logic              Ready;

    // Decode stage side: issues indices, write data and reservations.
    modport master (
        output RA, RB, RW, BusW, RegWr, RsvVld, RsvIdx,
        input  BusA, BusB, BusyA, BusyB, Ready
    );

    // Register file side.
    modport slave (
        input  RA, RB, RW, BusW, RegWr, RsvVld, RsvIdx,
        output BusA, BusB, BusyA, BusyB, Ready
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised 2-read/1-write register file with optional hardwired-zero entry,
// same-cycle write bypass, per-register busy scoreboard and a post-reset clear sweep.
module param_register_file #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_IDX = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                  Clk,
    input  logic                  ResetL,
    param_register_file_if.slave  rf
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic              readyQ;
    logic              readyNext;
    logic              clrWe;
    logic              wrEn;
    logic              rsvEn;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Next-state logic: CLEAR walks ptr over every entry, then hands over to RUN.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        readyNext = readyQ;
        clrWe     = 1'b0;
        case (state)
            CLEAR: begin
                clrWe   = 1'b1;
                ptrNext = ptr + ADDR_W'(1);
                if (ptr == LAST_A) begin
                    stateNext = RUN;
                    readyNext = 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                stateNext = CLEAR;
            end
        endcase
    end

    // Architectural updates are only honoured once the sweep has finished.
    assign wrEn  = (state == RUN) && rf.RegWr  && !(ZERO_EN && (rf.RW == ZERO_A));
    assign rsvEn = (state == RUN) && rf.RsvVld && !(ZERO_EN && (rf.RsvIdx == ZERO_A));

    // State, sweep pointer and Ready registers.
    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            state  <= CLEAR;
            ptr    <= '0;
            readyQ <= 1'b0;
        end else begin
            state  <= stateNext;
            ptr    <= ptrNext;
            readyQ <= readyNext;
        end
    end

    // Data array: no reset of its own, the sweep zeroes it after reset releases.
    always_ff @(posedge Clk) begin
        if (ResetL) begin
            if (clrWe) begin
                regs[ptr] <= '0;
            end else if (wrEn) begin
                regs[rf.RW] <= rf.BusW;
            end
        end
    end

    // Scoreboard: a write retires the producer, a reservation in the same cycle re-arms it.
    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            busy <= '0;
        end else begin
            if (wrEn) begin
                busy[rf.RW] <= 1'b0;
            end
            if (rsvEn) begin
                busy[rf.RsvIdx] <= 1'b1;
            end
        end
    end

    // Resolve one read port: returns {busy, data}.
    function automatic logic [DATA_W:0] readPort(
        input logic              run,
        input logic [ADDR_W-1:0] idx,
        input logic              wrReq,
        input logic [ADDR_W-1:0] wrIdx,
        input logic [DATA_W-1:0] wrData,
        input logic [DATA_W-1:0] entry,
        input logic              entryBusy
    );
        logic [DATA_W:0] res;
        res = {entryBusy, entry};
        if (!run || (ZERO_EN && (idx == ZERO_A))) begin
            res = '0;
        end else if (BYPASS && wrReq && (wrIdx == idx)) begin
            res = {1'b0, wrData};
        end
        return res;
    endfunction

    // Combinational read, port A.
    always_comb begin
        {rf.BusyA, rf.BusA} = readPort(state == RUN, rf.RA, rf.RegWr, rf.RW, rf.BusW,
                                       regs[rf.RA], busy[rf.RA]);
    end

    // Combinational read, port B.
    always_comb begin
        {rf.BusyB, rf.BusB} = readPort(state == RUN, rf.RB, rf.RegWr, rf.RW, rf.BusW,
                                       regs[rf.RB], busy[rf.RB]);
    end

    assign rf.Ready = readyQ;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three instances (default, no-zero/no-bypass, small 32x8),
// directed scenarios plus randomized traffic against an array-based reference model.
module tb_param_register_file;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic ResetL;

    // Per-instance stimulus: 0 = default, 1 = ZERO_EN=0/BYPASS=0, 2 = 32-bit x 8 entries.
    logic [4:0]  ra [3];
    logic [4:0]  rb [3];
    logic [4:0]  rw [3];
    logic [4:0]  rsvIdx [3];
    logic [63:0] busW [3];
    logic        regWr [3];
    logic        rsvVld [3];

    logic [63:0] actA [3];
    logic [63:0] actB [3];
    logic        actBa [3];
    logic        actBb [3];
    logic        actRdy [3];

    int checks = 0;
    int failures = 0;

    // Reference model configuration and state.
    int unsigned depthM  [3] = '{32, 32, 8};
    bit          zeroEnM [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  zeroIdxM[3] = '{5'd31, 5'd31, 5'd0};
    bit          bypassM [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] maskM   [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    logic [63:0] mMem [3][32];
    bit          mBusy[3][32];
    int unsigned mCnt [3];
    bit          mRdy [3];

    param_register_file_if #(.DATA_W(64), .ADDR_W(5)) ifD ();
    param_register_file_if #(.DATA_W(64), .ADDR_W(5)) ifN ();
    param_register_file_if #(.DATA_W(32), .ADDR_W(3)) ifS ();

    assign ifD.RA = ra[0];  assign ifD.RB = rb[0];  assign ifD.RW = rw[0];
    assign ifD.BusW = busW[0];  assign ifD.RegWr = regWr[0];
    assign ifD.RsvVld = rsvVld[0];  assign ifD.RsvIdx = rsvIdx[0];
    assign ifN.RA = ra[1];  assign ifN.RB = rb[1];  assign ifN.RW = rw[1];
    assign ifN.BusW = busW[1];  assign ifN.RegWr = regWr[1];
    assign ifN.RsvVld = rsvVld[1];  assign ifN.RsvIdx = rsvIdx[1];
    assign ifS.RA = ra[2][2:0];  assign ifS.RB = rb[2][2:0];  assign ifS.RW = rw[2][2:0];
    assign ifS.BusW = busW[2][31:0];  assign ifS.RegWr = regWr[2];
    assign ifS.RsvVld = rsvVld[2];  assign ifS.RsvIdx = rsvIdx[2][2:0];

    assign actA[0] = ifD.BusA;  assign actB[0] = ifD.BusB;
    assign actBa[0] = ifD.BusyA;  assign actBb[0] = ifD.BusyB;  assign actRdy[0] = ifD.Ready;
    assign actA[1] = ifN.BusA;  assign actB[1] = ifN.BusB;
    assign actBa[1] = ifN.BusyA;  assign actBb[1] = ifN.BusyB;  assign actRdy[1] = ifN.Ready;
    assign actA[2] = 64'(ifS.BusA);  assign actB[2] = 64'(ifS.BusB);
    assign actBa[2] = ifS.BusyA;  assign actBb[2] = ifS.BusyB;  assign actRdy[2] = ifS.Ready;

    param_register_file #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1'b1), .ZERO_IDX(31), .BYPASS(1'b1))
        dutD (.Clk(Clk), .ResetL(ResetL), .rf(ifD));
    param_register_file #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1'b0), .ZERO_IDX(31), .BYPASS(1'b0))
        dutN (.Clk(Clk), .ResetL(ResetL), .rf(ifN));
    param_register_file #(.DATA_W(32), .ADDR_W(3), .ZERO_EN(1'b1), .ZERO_IDX(0), .BYPASS(1'b1))
        dutS (.Clk(Clk), .ResetL(ResetL), .rf(ifS));

    // Expected {busy, data} for a read of idx on instance m with the current inputs.
    function automatic logic [64:0] expRead(input int m, input logic [4:0] idx);
        if (!mRdy[m]) return '0;
        if (zeroEnM[m] && idx == zeroIdxM[m]) return '0;
        if (bypassM[m] && regWr[m] && rw[m] == idx) return {1'b0, busW[m] & maskM[m]};
        return {mBusy[m][idx], mMem[m][idx]};
    endfunction

    // Apply one rising edge to the model.
    task automatic modelEdge();
        for (int m = 0; m < 3; m++) begin
            if (!ResetL) begin
                mCnt[m] = 0;
                mRdy[m] = 1'b0;
                for (int i = 0; i < 32; i++) mBusy[m][i] = 1'b0;
            end else if (!mRdy[m]) begin
                mMem[m][mCnt[m]] = '0;
                mCnt[m]++;
                if (mCnt[m] == depthM[m]) mRdy[m] = 1'b1;
            end else begin
                if (regWr[m] && !(zeroEnM[m] && rw[m] == zeroIdxM[m])) begin
                    mMem[m][rw[m]]  = busW[m] & maskM[m];
                    mBusy[m][rw[m]] = 1'b0;
                end
                if (rsvVld[m] && !(zeroEnM[m] && rsvIdx[m] == zeroIdxM[m]))
                    mBusy[m][rsvIdx[m]] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        modelEdge();
        @(negedge Clk);
    endtask

    task automatic idle();
        for (int m = 0; m < 3; m++) begin
            ra[m] = '0; rb[m] = '0; rw[m] = '0; rsvIdx[m] = '0;
            busW[m] = '0; regWr[m] = 1'b0; rsvVld[m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        ResetL = 1'b0;
        idle();
        tick();
        tick();
        #1;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (actRdy[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready m=%0d got=%b exp=0", m, actRdy[m]);
            end
        end
        ResetL = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            #1;
            checks++;
            if (actRdy[0] !== (k >= 32)) begin
                failures++;
                $display("FAIL sweep_ready edge=%0d got=%b exp=%b", k, actRdy[0], k >= 32);
            end
            checks++;
            if (actRdy[2] !== (k >= 8)) begin
                failures++;
                $display("FAIL small_sweep_ready edge=%0d got=%b exp=%b", k, actRdy[2], k >= 8);
            end
            if (k < 32) begin
                checks++;
                if (actA[0] !== 64'd0 || actBa[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL clear_forced edge=%0d busA=%h busyA=%b exp=0/0", k, actA[0], actBa[0]);
                end
            end
        end
        for (int i = 0; i < 31; i++) begin
            ra[0] = 5'(i);
            #1;
            checks++;
            if (actA[0] !== 64'd0 || actBa[0] !== 1'b0) begin
                failures++;
                $display("FAIL post_clear_read r=%0d busA=%h busyA=%b exp=0/0", i, actA[0], actBa[0]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        ResetL = 1'b0;
        tick();
        ResetL = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        ResetL = 1'b0;
        tick();
        ResetL = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                for (int m = 0; m < 2; m++) begin
                    regWr[m] = 1'b1; rw[m] = 5'd3; busW[m] = 64'h3;
                    rsvVld[m] = 1'b1; rsvIdx[m] = 5'd3;
                end
            end else if (k == 7) begin
                idle();
            end
            tick();
            #1;
            checks++;
            if (actRdy[0] !== (k >= 32)) begin
                failures++;
                $display("FAIL restart_ready edge=%0d got=%b exp=%b", k, actRdy[0], k >= 32);
            end
        end
        for (int m = 0; m < 2; m++) ra[m] = 5'd3;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (actA[m] !== 64'd0 || actBa[m] !== 1'b0) begin
                failures++;
                $display("FAIL clear_ignore m=%0d busA=%h busyA=%b exp=0/0", m, actA[m], actBa[m]);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_write_read();
        for (int m = 0; m < 2; m++) begin
            regWr[m] = 1'b1; rw[m] = 5'd5; busW[m] = 64'hDEAD_BEEF_0123_4567; ra[m] = 5'd5;
        end
        #1;
        checks++;
        if (actA[0] !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL bypass_read got=%h exp=%h", actA[0], 64'hDEAD_BEEF_0123_4567);
        end
        checks++;
        if (actA[1] !== 64'd0) begin
            failures++;
            $display("FAIL nobypass_old got=%h exp=0", actA[1]);
        end
        tick();
        idle();
        for (int m = 0; m < 2; m++) ra[m] = 5'd5;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (actA[m] !== 64'hDEAD_BEEF_0123_4567) begin
                failures++;
                $display("FAIL write_readback m=%0d got=%h exp=%h", m, actA[m], 64'hDEAD_BEEF_0123_4567);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_zero();
        for (int m = 0; m < 2; m++) begin
            regWr[m] = 1'b1; rw[m] = 5'd31; busW[m] = 64'hFFFF_FFFF_FFFF_FFFF;
            rsvVld[m] = 1'b1; rsvIdx[m] = 5'd31; ra[m] = 5'd31; rb[m] = 5'd31;
        end
        #1;
        checks++;
        if (actA[0] !== 64'd0 || actB[0] !== 64'd0 || actBa[0] !== 1'b0 || actBb[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_write_cycle busA=%h busB=%h busy=%b%b exp=0", actA[0], actB[0], actBa[0], actBb[0]);
        end
        tick();
        idle();
        for (int m = 0; m < 2; m++) begin
            ra[m] = 5'd31; rb[m] = 5'd31;
        end
        #1;
        checks++;
        if (actA[0] !== 64'd0 || actB[0] !== 64'd0 || actBa[0] !== 1'b0 || actBb[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_after busA=%h busB=%h busy=%b%b exp=0", actA[0], actB[0], actBa[0], actBb[0]);
        end
        checks++;
        if (actA[1] !== 64'hFFFF_FFFF_FFFF_FFFF || actB[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL nozero_readback busA=%h busB=%h exp=all-ones", actA[1], actB[1]);
        end
        checks++;
        if (actBa[1] !== 1'b1) begin
            failures++;
            $display("FAIL nozero_busy got=%b exp=1", actBa[1]);
        end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        for (int m = 0; m < 2; m++) begin
            rsvVld[m] = 1'b1; rsvIdx[m] = 5'd7;
        end
        tick();
        idle();
        for (int m = 0; m < 2; m++) ra[m] = 5'd7;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (actBa[m] !== 1'b1) begin
                failures++;
                $display("FAIL rsv_busy m=%0d got=%b exp=1", m, actBa[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            regWr[m] = 1'b1; rw[m] = 5'd7; busW[m] = 64'h7; ra[m] = 5'd7;
        end
        #1;
        checks++;
        if (actBa[0] !== 1'b0 || actA[0] !== 64'h7) begin
            failures++;
            $display("FAIL write_cycle_bypass busyA=%b busA=%h exp=0/7", actBa[0], actA[0]);
        end
        checks++;
        if (actBa[1] !== 1'b1 || actA[1] !== 64'h0) begin
            failures++;
            $display("FAIL write_cycle_nobypass busyA=%b busA=%h exp=1/0", actBa[1], actA[1]);
        end
        tick();
        idle();
        for (int m = 0; m < 2; m++) ra[m] = 5'd7;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (actBa[m] !== 1'b0 || actA[m] !== 64'h7) begin
                failures++;
                $display("FAIL after_write m=%0d busyA=%b busA=%h exp=0/7", m, actBa[m], actA[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            regWr[m] = 1'b1; rw[m] = 5'd7; busW[m] = 64'h77;
            rsvVld[m] = 1'b1; rsvIdx[m] = 5'd7;
        end
        tick();
        idle();
        for (int m = 0; m < 2; m++) ra[m] = 5'd7;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (actBa[m] !== 1'b1 || actA[m] !== 64'h77) begin
                failures++;
                $display("FAIL rsv_wins m=%0d busyA=%b busA=%h exp=1/77", m, actBa[m], actA[m]);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_small();
        regWr[2] = 1'b1; rw[2] = 5'd7; busW[2] = 64'hA5A5_A5A5;
        rsvVld[2] = 1'b1; rsvIdx[2] = 5'd0; ra[2] = 5'd7; rb[2] = 5'd0;
        #1;
        checks++;
        if (actA[2] !== 64'hA5A5_A5A5 || actB[2] !== 64'd0 || actBb[2] !== 1'b0) begin
            failures++;
            $display("FAIL small_bypass busA=%h busB=%h busyB=%b exp=a5a5a5a5/0/0", actA[2], actB[2], actBb[2]);
        end
        tick();
        idle();
        regWr[2] = 1'b1; rw[2] = 5'd0; busW[2] = 64'h1234; ra[2] = 5'd0; rb[2] = 5'd7;
        #1;
        checks++;
        if (actA[2] !== 64'd0 || actBa[2] !== 1'b0 || actB[2] !== 64'hA5A5_A5A5) begin
            failures++;
            $display("FAIL small_zero_write busA=%h busyA=%b busB=%h exp=0/0/a5a5a5a5", actA[2], actBa[2], actB[2]);
        end
        tick();
        idle();
        ra[2] = 5'd0;
        #1;
        checks++;
        if (actA[2] !== 64'd0 || actBa[2] !== 1'b0) begin
            failures++;
            $display("FAIL small_zero_after busA=%h busyA=%b exp=0/0", actA[2], actBa[2]);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [64:0] eA;
        logic [64:0] eB;
        for (int c = 0; c < 600; c++) begin
            ResetL = ($urandom_range(0, 249) != 0);
            for (int m = 0; m < 3; m++) begin
                ra[m]     = 5'($urandom_range(0, depthM[m] - 1));
                rb[m]     = ($urandom_range(0, 3) == 0) ? ra[m] : 5'($urandom_range(0, depthM[m] - 1));
                rw[m]     = ($urandom_range(0, 2) == 0) ? ra[m] : 5'($urandom_range(0, depthM[m] - 1));
                rsvIdx[m] = ($urandom_range(0, 2) == 0) ? rw[m] : 5'($urandom_range(0, depthM[m] - 1));
                busW[m]   = {$urandom, $urandom} & maskM[m];
                regWr[m]  = 1'($urandom_range(0, 1));
                rsvVld[m] = ($urandom_range(0, 2) == 0);
            end
            #1;
            for (int m = 0; m < 3; m++) begin
                eA = expRead(m, ra[m]);
                eB = expRead(m, rb[m]);
                checks++;
                if (actA[m] !== eA[63:0] || actBa[m] !== eA[64]) begin
                    failures++;
                    $display("FAIL rand_portA m=%0d cyc=%0d got=%b/%h exp=%b/%h", m, c, actBa[m], actA[m], eA[64], eA[63:0]);
                end
                checks++;
                if (actB[m] !== eB[63:0] || actBb[m] !== eB[64]) begin
                    failures++;
                    $display("FAIL rand_portB m=%0d cyc=%0d got=%b/%h exp=%b/%h", m, c, actBb[m], actB[m], eB[64], eB[63:0]);
                end
                checks++;
                if (actRdy[m] !== mRdy[m]) begin
                    failures++;
                    $display("FAIL rand_ready m=%0d cyc=%0d got=%b exp=%b", m, c, actRdy[m], mRdy[m]);
                end
            end
            tick();
        end
        ResetL = 1'b1;
        idle();
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            mCnt[m] = 0;
            mRdy[m] = 1'b0;
            for (int i = 0; i < 32; i++) begin
                mMem[m][i]  = '0;
                mBusy[m][i] = 1'b0;
            end
        end
        ResetL = 1'b0;
        idle();
        test_reset();
        test_reset_mid();
        test_write_read();
        test_zero();
        test_scoreboard();
        test_small();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
